uart_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
//  - Sits between the status/debug sources of the LED controller and the UART TX core.
//  - Sequences the TX core's load/ready handshake one byte at a time.
//  - Holds the grant until the requester's last byte has been sent.

---
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one UART TX core between NUM_REQ byte streams.
// Define UART_ARB_HEADER_EN to prefix every packet with a {HEADER_TAG, owner} header byte.
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         MAX_PKT_LEN = 16,
  parameter logic [3:0] HEADER_TAG  = 4'hA
) (
  input  logic                 clockIN,
  input  logic                 nResetIN,
  input  logic [NUM_REQ-1:0]   reqIN,
  input  logic [8*NUM_REQ-1:0] reqDataIN,
  input  logic [NUM_REQ-1:0]   reqLastIN,
  output logic [NUM_REQ-1:0]   ackOUT,
  output logic [NUM_REQ-1:0]   grantOUT,
  output logic                 busyOUT,
  output logic                 truncOUT,
  output logic [7:0]           txDataOUT,
  output logic                 txLoadOUT,
  input  logic                 txReadyIN
);
  localparam int ptrW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {
    IDLE,
`ifdef UART_ARB_HEADER_EN
    HDR,
`endif
    FETCH,
    LOAD,
    DRAIN
  } stateT;
  stateT state, nextState;
  logic [ptrW-1:0] rrPtr, gIdx, winIdx;
  logic [ptrW:0] k;
  logic winFound, lastReg, truncReg, gReq, gLast, cntEnd;
  logic [7:0] byteCnt, gData;
  assign gReq = reqIN[gIdx];
  assign gLast = reqLastIN[gIdx];
  assign gData = reqDataIN[{gIdx, 3'b000} +: 8];
  assign cntEnd = byteCnt == 8'(MAX_PKT_LEN - 1);
  // Scan from farthest to nearest so the requester closest after rrPtr wins.
  always_comb begin
    winFound = 1'b0;
    winIdx = '0;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = {1'b0, rrPtr} + (ptrW+1)'(i);
      k = k >= (ptrW+1)'(NUM_REQ) ? k - (ptrW+1)'(NUM_REQ) : k;
      if (reqIN[k[ptrW-1:0]]) begin
        winFound = 1'b1;
        winIdx = k[ptrW-1:0];
      end
    end
  end
  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
`ifdef UART_ARB_HEADER_EN
      IDLE:  nextState = winFound ? HDR : IDLE;
      HDR:   nextState = LOAD;
`else
      IDLE:  nextState = winFound ? FETCH : IDLE;
`endif
      FETCH: nextState = gReq ? LOAD : FETCH;
      LOAD:  nextState = txReadyIN ? LOAD : DRAIN;
      DRAIN: nextState = !txReadyIN ? DRAIN : lastReg ? IDLE : FETCH;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rrPtr <= ptrW'(NUM_REQ - 1);
      gIdx <= '0;
      grantOUT <= '0;
      byteCnt <= '0;
      lastReg <= 1'b0;
      truncReg <= 1'b0;
      txDataOUT <= 8'h00;
    end else begin
      case (state)
        IDLE: if (winFound) begin
          gIdx <= winIdx;
          grantOUT <= NUM_REQ'(1) << winIdx;
          byteCnt <= '0;
        end
`ifdef UART_ARB_HEADER_EN
        HDR: begin
          txDataOUT <= {HEADER_TAG, 4'(gIdx)};
          lastReg <= 1'b0;
          truncReg <= 1'b0;
        end
`endif
        FETCH: if (gReq) begin
          txDataOUT <= gData;
          lastReg <= gLast | cntEnd;
          truncReg <= !gLast & cntEnd;
          byteCnt <= byteCnt + 8'd1;
        end
        DRAIN: if (txReadyIN && lastReg) begin
          rrPtr <= gIdx;
          grantOUT <= '0;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    ackOUT = (state == FETCH && gReq) ? grantOUT : '0;
    txLoadOUT = state == LOAD;
    busyOUT = state != IDLE;
    truncOUT = state == DRAIN && txReadyIN && lastReg && truncReg;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench; a packet-level round-robin model predicts every line byte and its owner.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int MAXP = 4;
  logic clockIN = 1'b0;
  logic nResetIN = 1'b0;
  logic [N-1:0] reqIN, reqLastIN, ackOUT, grantOUT;
  logic [8*N-1:0] reqDataIN;
  logic busyOUT, truncOUT, txLoadOUT, txReadyIN;
  logic [7:0] txDataOUT;
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXP), .HEADER_TAG(4'hA)) dut (
    .clockIN(clockIN), .nResetIN(nResetIN), .reqIN(reqIN), .reqDataIN(reqDataIN),
    .reqLastIN(reqLastIN), .ackOUT(ackOUT), .grantOUT(grantOUT), .busyOUT(busyOUT),
    .truncOUT(truncOUT), .txDataOUT(txDataOUT), .txLoadOUT(txLoadOUT), .txReadyIN(txReadyIN)
  );
  always #5 clockIN = ~clockIN;
  int checks = 0, fails = 0;
  logic [8:0] mem [N][1024];
  int head[N], tail[N], pcnt[N], mHead[N];
  int mPtr = N - 1;
  logic [11:0] expQ[$];
  int ackCnt = 0, expAck = 0, truncCnt = 0, expTrunc = 0;
  int latCnt = 0, shiftCnt = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic addByte(input int i, input logic [7:0] d, input logic last);
    mem[i][tail[i]] = {last, d};
    tail[i]++;
  endtask
  // Reference: whole packets granted round-robin, capped at MAXP bytes.
  task automatic runModel();
    int w, n, c;
    logic [8:0] b;
    bit done;
    forever begin
      w = -1;
      for (int s = 1; s <= N; s++) begin
        c = (mPtr + s) % N;
        if (w < 0 && mHead[c] < tail[c]) w = c;
      end
      if (w < 0) break;
`ifdef UART_ARB_HEADER_EN
      expQ.push_back({w[3:0], 4'hA, w[3:0]});
`endif
      n = 0;
      done = 0;
      while (!done) begin
        b = mem[w][mHead[w]];
        mHead[w]++;
        n++;
        expQ.push_back({w[3:0], b[7:0]});
        expAck++;
        done = b[8] || n == MAXP || mHead[w] == tail[w];
      end
      if (n == MAXP && !b[8]) expTrunc++;
      mPtr = w;
    end
  endtask
  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) pending = 1;
  endfunction
  task automatic runPhase(input string nm);
    int cyc;
    runModel();
    cyc = 0;
    while ((expQ.size() != 0 || busyOUT || pending()) && cyc < 5000) begin
      @(negedge clockIN);
      cyc++;
    end
    check({nm, "_timeout"}, cyc < 5000, 1);
    check({nm, "_acks"}, ackCnt, expAck);
    check({nm, "_truncs"}, truncCnt, expTrunc);
    check({nm, "_idle_grant"}, grantOUT, 0);
  endtask
  // Requesters and TX core model: sample at negedge, drive just after posedge.
  initial begin : drive
    logic [N-1:0] ackS;
    bit dropR, raiseR;
    forever begin
      @(negedge clockIN);
      ackS = ackOUT;
      dropR = 0;
      raiseR = 0;
      if (txReadyIN && txLoadOUT) begin
        if (latCnt == 0) dropR = 1;
        else latCnt--;
      end else if (!txReadyIN) begin
        shiftCnt--;
        if (shiftCnt <= 0) raiseR = 1;
      end
      @(posedge clockIN);
      #1;
      if (dropR) begin
        txReadyIN = 0;
        shiftCnt = $urandom_range(1, 4);
      end
      if (raiseR) begin
        txReadyIN = 1;
        latCnt = $urandom_range(0, 3);
      end
      for (int i = 0; i < N; i++) begin
        if (ackS[i]) begin
          pcnt[i] = (mem[i][head[i]][8] || pcnt[i] + 1 == MAXP) ? 0 : pcnt[i] + 1;
          head[i]++;
        end
        if (head[i] < tail[i] && !(pcnt[i] != 0 && $urandom_range(0, 3) == 0)) begin
          reqIN[i] = 1'b1;
          reqDataIN[8*i +: 8] = mem[i][head[i]][7:0];
          reqLastIN[i] = mem[i][head[i]][8];
        end else begin
          reqIN[i] = 1'b0;
          reqDataIN[8*i +: 8] = 8'($urandom);
          reqLastIN[i] = 1'($urandom);
        end
      end
    end
  end
  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(negedge clockIN);
      if (nResetIN && txLoadOUT && !txReadyIN) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL line_extra: got byte %0h, expected no byte", txDataOUT);
        end else begin
          e = expQ.pop_front();
          check("line_data", txDataOUT, e[7:0]);
          check("line_owner", grantOUT, 32'(1) << e[11:8]);
        end
      end
      if (ackOUT != 0) begin
        ackCnt++;
        check("ack_onehot", $onehot(ackOUT), 1);
        check("ack_granted", ackOUT & ~grantOUT, 0);
      end
      if (truncOUT) truncCnt++;
    end
  end
  initial begin : main
    int np, len, cyc;
    reqIN = '0;
    reqDataIN = '0;
    reqLastIN = '0;
    txReadyIN = 1'b1;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      pcnt[i] = 0;
      mHead[i] = 0;
    end
    repeat (3) @(negedge clockIN);
    check("rst_grant", grantOUT, 0);
    check("rst_ack", ackOUT, 0);
    check("rst_busy", busyOUT, 0);
    check("rst_trunc", truncOUT, 0);
    check("rst_load", txLoadOUT, 0);
    check("rst_data", txDataOUT, 0);
    nResetIN = 1'b1;
    addByte(0, 8'h55, 1);
    runPhase("single");
    addByte(1, 8'h11, 1);
    addByte(1, 8'h12, 1);
    addByte(3, 8'h31, 1);
    addByte(3, 8'h32, 1);
    runPhase("contention");
    addByte(2, 8'h01, 0);
    addByte(2, 8'h02, 0);
    addByte(2, 8'h03, 1);
    addByte(0, 8'h0F, 1);
    runPhase("hold");
    for (int b = 0; b < 6; b++) addByte(1, 8'(8'h60 + b), b == 5);
    runPhase("trunc");
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) addByte(i, 8'($urandom), b == len - 1);
        end
      end
      runPhase("random");
    end
    addByte(2, 8'hE1, 0);
    addByte(2, 8'hE2, 1);
    runModel();
    cyc = 0;
    while (!(txLoadOUT && txReadyIN) && cyc < 200) begin
      @(negedge clockIN);
      cyc++;
    end
    check("midload_reached", cyc < 200, 1);
    #2 nResetIN = 1'b0;
    #1;
    check("async_load", txLoadOUT, 0);
    check("async_grant", grantOUT, 0);
    check("async_busy", busyOUT, 0);
    check("async_data", txDataOUT, 0);
    check("async_ack", ackOUT, 0);
    for (int i = 0; i < N; i++) begin
      head[i] = tail[i];
      mHead[i] = tail[i];
      pcnt[i] = 0;
    end
    expQ.delete();
    mPtr = N - 1;
    ackCnt = 0;
    expAck = 0;
    truncCnt = 0;
    expTrunc = 0;
    repeat (12) @(negedge clockIN);
    check("rst_hold_ack", ackCnt, 0);
    nResetIN = 1'b1;
    addByte(3, 8'hD3, 1);
    addByte(0, 8'hD0, 1);
    runPhase("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
